// File: rtl/bus_sram_slave_if.sv
// Request/response bundle between a CPU master port and the SRAM slave.
// Signals: addr/wr/valid/dataM2S from master, ready/dataS2M from slave.
// Master holds addr/wr/dataM2S stable while valid is high until ready.
interface bus_sram_slave_if;
  logic [31:0] addr;
  logic        wr;
  logic        valid;
  logic [31:0] dataM2S;
  logic        ready;
  logic [31:0] dataS2M;

  modport master (
    output addr, wr, valid, dataM2S,
    input  ready, dataS2M
  );

  modport slave (
    input  addr, wr, valid, dataM2S,
    output ready, dataS2M
  );
endinterface

// File: rtl/bus_sram_slave.sv
// Word-addressed single-port SRAM slave with configurable wait states.
// Latency: ready in cycle W+1 of continuous valid; read data registered and held.
// Backpressure: ready held low while wait states elapse; dropping valid aborts.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - slave modport: addr, wr, valid, dataM2S in; ready, dataS2M out
//
// Optional feature macro BUS_SRAM_RANDOM_WAIT_EN: when defined, the effective
// wait is P_WAIT + lfsr[1:0], where a 16-bit Fibonacci LFSR (taps 16,14,13,11,
// seeded with P_SEED) steps once per completed transaction.
module bus_sram_slave #(
  parameter int          P_DEPTH_LOG2 = 10,
  parameter int          P_WAIT       = 0,
  parameter string       P_INIT_FILE  = "",
  parameter logic [15:0] P_SEED       = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  bus_sram_slave_if.slave  bus
);

  localparam int DEPTH = 1 << P_DEPTH_LOG2;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                  state_q;
  logic [4:0]              cnt_q;
  logic [31:0]             dat_q;
  logic [31:0]             mem_q [DEPTH];
  logic [P_DEPTH_LOG2-1:0] idx;
  logic [4:0]              wait_d;
  logic                    ready_d;

  // Upper address bits and byte offset are ignored: accesses alias modulo depth.
  assign idx = bus.addr[P_DEPTH_LOG2+1:2];

  logic unused_addr;
  assign unused_addr = ^{bus.addr[31:P_DEPTH_LOG2+2], bus.addr[1:0]};

`ifdef BUS_SRAM_RANDOM_WAIT_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign wait_d  = 5'(P_WAIT) + {3'b000, lfsr_q[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= P_SEED;
    end else if (ready_d) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end
`else
  logic unused_seed;
  assign unused_seed = ^P_SEED;
  assign wait_d      = 5'(P_WAIT);
`endif

  // ready is combinational so a zero-wait slave completes in the request
  // cycle; qualifying with rst keeps it low (and blocks commits) in reset.
  always_comb begin
    ready_d = 1'b0;
    if (rst && bus.valid) begin
      case (state_q)
        S_IDLE:  ready_d = (wait_d == 5'd0);
        S_WAIT:  ready_d = (cnt_q == 5'd0);
        default: ready_d = 1'b0;
      endcase
    end
  end

  assign bus.ready   = ready_d;
  assign bus.dataS2M = dat_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      dat_q   <= 32'h0;
    end else begin
      if (ready_d && !bus.wr) begin
        dat_q <= mem_q[idx];
      end
      case (state_q)
        S_IDLE: begin
          if (bus.valid && wait_d != 5'd0) begin
            cnt_q   <= wait_d - 5'd1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A dropped valid abandons the request without committing.
          if (!bus.valid || ready_d) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Storage is not reset; writes are gated by ready, which is low in reset.
  always_ff @(posedge clk) begin
    if (ready_d && bus.wr) begin
      mem_q[idx] <= bus.dataM2S;
    end
  end

endmodule

// File: tb/tb_bus_sram_slave.sv
module tb_bus_sram_slave;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  valid_v = '0;
  logic [3:0]  wr_v = '0;
  logic [31:0] addr_v [4];
  logic [31:0] dm_v [4];
  logic [3:0]  rdy_v;
  logic [31:0] dat_v [4];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic int dep_of(input int k);
    return (k == 0) ? 4 : 6;
  endfunction

  function automatic int base_wait(input int k);
    case (k)
      0: return 0;
      1: return 3;
      2: return 4;
      default: return 1;
    endcase
  endfunction

  // Four instances cover the distinct wait/depth configurations.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    bus_sram_slave_if u_bus ();
    assign u_bus.valid   = valid_v[g];
    assign u_bus.wr      = wr_v[g];
    assign u_bus.addr    = addr_v[g];
    assign u_bus.dataM2S = dm_v[g];
    assign rdy_v[g]      = u_bus.ready;
    assign dat_v[g]      = u_bus.dataS2M;

    bus_sram_slave #(
      .P_DEPTH_LOG2 ((g == 0) ? 4 : 6),
      .P_WAIT       ((g == 0) ? 0 : (g == 1) ? 3 : (g == 2) ? 4 : 1),
      .P_INIT_FILE  (""),
      .P_SEED       (SEED)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_bus)
    );
  end

  // ---------------- reference model ----------------
  logic [31:0] mmem [4][64];
  int          age [4];
  logic [31:0] exp_dat [4];
  logic [15:0] mlfsr [4];

  function automatic int idx_of(input int k, input logic [31:0] a);
    return int'((a >> 2) % (32'd1 << dep_of(k)));
  endfunction

  function automatic int wait_of(input int k);
`ifdef BUS_SRAM_RANDOM_WAIT_EN
    return base_wait(k) + int'(mlfsr[k][1:0]);
`else
    return base_wait(k);
`endif
  endfunction

  // A request completes once it has been valid for W+1 consecutive cycles.
  function automatic logic exp_rdy(input int k);
    return (rst === 1'b1) && valid_v[k] && (age[k] == wait_of(k));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        age[k]     = 0;
        exp_dat[k] = 32'h0;
        mlfsr[k]   = SEED;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (exp_rdy(k)) begin
          if (wr_v[k]) mmem[k][idx_of(k, addr_v[k])] = dm_v[k];
          else         exp_dat[k] = mmem[k][idx_of(k, addr_v[k])];
          age[k]   = 0;
          mlfsr[k] = {mlfsr[k][14:0],
                      mlfsr[k][15] ^ mlfsr[k][13] ^ mlfsr[k][12] ^ mlfsr[k][10]};
        end else if (valid_v[k]) begin
          age[k] = age[k] + 1;
        end else begin
          age[k] = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every instance against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (rdy_v[k] !== exp_rdy(k)) begin
        n_fail++;
        $display("FAIL ready[%0d]: got %b expected %b at %0t", k, rdy_v[k], exp_rdy(k), $time);
      end
      n_chk++;
      if (dat_v[k] !== exp_dat[k]) begin
        n_fail++;
        $display("FAIL dataS2M[%0d]: got %h expected %h at %0t", k, dat_v[k], exp_dat[k], $time);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic req(input int k, input bit w, input logic [31:0] a,
                     input logic [31:0] d, output int lat);
    valid_v[k] = 1'b1;
    wr_v[k]    = w;
    addr_v[k]  = a;
    dm_v[k]    = d;
    lat        = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (rdy_v[k] === 1'b1) break;
      if (lat >= 40) begin
        n_chk++;
        n_fail++;
        $display("FAIL timeout[%0d]: got no ready after %0d cycles, required ready", k, lat);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid_v = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    valid_v = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  int lat;
  int seen;
  int lat1 [100];

  initial begin
    for (int k = 0; k < 4; k++) begin
      addr_v[k] = '0;
      dm_v[k]   = '0;
    end
    do_reset();
    for (int k = 0; k < 4; k++) begin
      chk("reset_ready", {31'b0, rdy_v[k]}, 32'h0);
      chk("reset_data", dat_v[k], 32'h0);
    end

    // Fill every word so all later reads have defined contents.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < (1 << dep_of(k)); i++) req(k, 1'b1, i * 4, $urandom, lat);
      idle(1);
    end

    // Zero-wait write then read of the same word.
    req(0, 1'b1, 32'h40, 32'hDEADBEEF, lat);
    chk("w0_wr_lat", lat, 1);
    req(0, 1'b0, 32'h40, 32'h0, lat);
    chk("w0_rd_lat", lat, 1);
    chk("w0_raw_data", dat_v[0], 32'hDEADBEEF);
    idle(1);

    // Three wait states: ready in cycle 4, data held while idle.
    req(1, 1'b1, 32'h8, 32'h12345678, lat);
    idle(2);
    req(1, 1'b0, 32'h8, 32'h0, lat);
    chk("w3_lat", lat, 4);
    valid_v = '0;
    for (int i = 0; i < 5; i++) begin
      chk("w3_hold", dat_v[1], 32'h12345678);
      @(posedge clk);
      #1;
    end

    // Back-to-back streaming: 8 writes then 8 reads with valid held high.
    for (int i = 0; i < 8; i++) req(0, 1'b1, i * 4, i, lat);
    for (int i = 0; i < 8; i++) begin
      req(0, 1'b0, i * 4, 32'h0, lat);
      chk("stream_lat", lat, 1);
      chk("stream_data", dat_v[0], i);
    end
    idle(1);

    // Aliasing in a 16-word memory and ignored byte offset.
    req(0, 1'b1, 32'h44, 32'hA5A5A5A5, lat);
    req(0, 1'b0, 32'h04, 32'h0, lat);
    chk("alias_data", dat_v[0], 32'hA5A5A5A5);
    req(0, 1'b0, 32'h47, 32'h0, lat);
    chk("offset_data", dat_v[0], 32'hA5A5A5A5);
    idle(1);

    // Aborted write on a 4-wait slave leaves memory untouched.
    req(2, 1'b1, 32'h20, 32'h0BADF00D, lat);
    req(2, 1'b1, 32'h24, 32'h11112222, lat);
    idle(1);
    valid_v[2] = 1'b1; wr_v[2] = 1'b1; addr_v[2] = 32'h20; dm_v[2] = 32'hFFFF0000;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (rdy_v[2] === 1'b1) seen++;
      @(posedge clk);
      #1;
    end
    chk("abort_no_ready", seen, 0);
    idle(1);
    req(2, 1'b0, 32'h20, 32'h0, lat);
    chk("abort_lat", lat, 5);
    chk("abort_old_data", dat_v[2], 32'h0BADF00D);
    idle(1);

    // Reset in the middle of a waiting write.
    valid_v[2] = 1'b1; wr_v[2] = 1'b1; addr_v[2] = 32'h24; dm_v[2] = 32'hCAFEF00D;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #2;
    chk("midrst_ready", {31'b0, rdy_v[2]}, 32'h0);
    chk("midrst_data", dat_v[2], 32'h0);
    @(posedge clk);
    #1;
    valid_v = '0;
    rst = 1'b1;
    idle(1);
    req(2, 1'b0, 32'h24, 32'h0, lat);
    chk("midrst_lat", lat, 5);
    chk("midrst_old_data", dat_v[2], 32'h11112222);
    idle(1);

    // Randomised mixed traffic on every instance.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 60; i++) begin
        req(k, 1'($urandom), $urandom, $urandom, lat);
        if ($urandom_range(2) == 0) idle($urandom_range(3, 1));
      end
      idle(1);
    end

    // 100 back-to-back reads on the 1-wait slave, twice from reset.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      req(3, 1'b0, $urandom, 32'h0, lat);
      lat1[i] = lat;
      chk("lat_range", {31'b0, (lat >= 2 && lat <= 5)}, 32'h1);
    end
    do_reset();
    for (int i = 0; i < 100; i++) begin
      req(3, 1'b0, $urandom, 32'h0, lat);
      chk("lat_repeat", lat, lat1[i]);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
